// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-port SRAM (registered read output) between the CPU
// instruction-fetch requester (IF) and the data-memory requester (DM).
// Every access is two cycles: an issue cycle in IDLE, where the granted
// requester drives the SRAM pins, and an ack cycle in IF_WAIT/DM_WAIT, where
// the SRAM's registered read data is handed back. DM has fixed priority, but
// after MAX_DM_STREAK consecutive DM grants with IF waiting, IF wins once.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   if_req_i, if_addr_i     IF request and word address
//   if_ack_o, if_rdata_o    IF completion pulse and fetched word (0 otherwise)
//   dm_req_i, dm_web_i      DM request and active-low byte write enables
//   dm_addr_i, dm_wdata_i   DM word address and byte-aligned write data
//   dm_ack_o, dm_rdata_o    DM completion pulse and read data (0 otherwise)
//   sram_cs_o, sram_oe_o    SRAM chip select and output enable
//   sram_web_o              SRAM active-low byte write enables
//   sram_a_o, sram_di_o     SRAM address and write data
//   sram_do_i               SRAM read data, valid the cycle after issue
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int unsigned ADDR_W        = 14,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic [3:0]        dm_web_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              sram_cs_o,
    output logic              sram_oe_o,
    output logic [3:0]        sram_web_o,
    output logic [ADDR_W-1:0] sram_a_o,
    output logic [DATA_W-1:0] sram_di_o,
    input  logic [DATA_W-1:0] sram_do_i
);

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        DM_WAIT
    } state_e;

    localparam logic [3:0] MaxStreak = 4'(MAX_DM_STREAK);

    state_e     state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       dmRead_q, dmRead_d;
    logic       grantDm, grantIf;

    // Arbitration only happens in IDLE. DM wins unless IF has already been
    // passed over MAX_DM_STREAK times in a row.
    always_comb begin
        grantDm = 1'b0;
        grantIf = 1'b0;
        if (state_q == IDLE) begin
            if (dm_req_i && !(if_req_i && (streak_q == MaxStreak))) begin
                grantDm = 1'b1;
            end else if (if_req_i) begin
                grantIf = 1'b1;
            end
        end
    end

    // State register. Reset abandons any access in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
            dmRead_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            dmRead_q <= dmRead_d;
        end
    end

    // Next-state logic. The streak only grows while IF is actually waiting;
    // a DM grant with no IF pending or any IF grant clears it.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        dmRead_d = dmRead_q;
        case (state_q)
            IDLE: begin
                if (grantDm) begin
                    state_d  = DM_WAIT;
                    dmRead_d = (dm_web_i == 4'hF);
                    if (if_req_i) begin
                        streak_d = (streak_q == MaxStreak) ? streak_q : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end else if (grantIf) begin
                    state_d  = IF_WAIT;
                    streak_d = 4'd0;
                end
            end
            IF_WAIT: state_d = IDLE;
            DM_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Everything is gated by rst_i so that the reset cycle
    // keeps the SRAM idle and never produces an ack for an abandoned access.
    always_comb begin
        sram_cs_o  = 1'b0;
        sram_oe_o  = 1'b0;
        sram_web_o = 4'hF;
        sram_a_o   = '0;
        sram_di_o  = '0;
        if_ack_o   = 1'b0;
        if_rdata_o = '0;
        dm_ack_o   = 1'b0;
        dm_rdata_o = '0;
        if (rst_i) begin
            if (grantDm) begin
                sram_cs_o  = 1'b1;
                sram_oe_o  = (dm_web_i == 4'hF);
                sram_web_o = dm_web_i;
                sram_a_o   = dm_addr_i;
                sram_di_o  = dm_wdata_i;
            end else if (grantIf) begin
                sram_cs_o  = 1'b1;
                sram_oe_o  = 1'b1;
                sram_a_o   = if_addr_i;
            end
            if (state_q == IF_WAIT) begin
                if_ack_o   = 1'b1;
                if_rdata_o = sram_do_i;
            end
            if (state_q == DM_WAIT) begin
                dm_ack_o = 1'b1;
                if (dmRead_q) begin
                    dm_rdata_o = sram_do_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed bench for sram_port_arbiter with a behavioural SRAM that has a
// registered read port. Inputs are driven on the falling edge and outputs
// are sampled 1ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ifReq = 1'b0;
    logic [ADDR_W-1:0] ifAddr = '0;
    logic              ifAck;
    logic [DATA_W-1:0] ifRdata;
    logic              dmReq = 1'b0;
    logic [3:0]        dmWeb = 4'hF;
    logic [ADDR_W-1:0] dmAddr = '0;
    logic [DATA_W-1:0] dmWdata = '0;
    logic              dmAck;
    logic [DATA_W-1:0] dmRdata;
    logic              sramCs;
    logic              sramOe;
    logic [3:0]        sramWeb;
    logic [ADDR_W-1:0] sramA;
    logic [DATA_W-1:0] sramDi;
    logic [DATA_W-1:0] sramDo = '0;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem [0:255];

    sram_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_DM_STREAK(4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .if_req_i  (ifReq),
        .if_addr_i (ifAddr),
        .if_ack_o  (ifAck),
        .if_rdata_o(ifRdata),
        .dm_req_i  (dmReq),
        .dm_web_i  (dmWeb),
        .dm_addr_i (dmAddr),
        .dm_wdata_i(dmWdata),
        .dm_ack_o  (dmAck),
        .dm_rdata_o(dmRdata),
        .sram_cs_o (sramCs),
        .sram_oe_o (sramOe),
        .sram_web_o(sramWeb),
        .sram_a_o  (sramA),
        .sram_di_o (sramDi),
        .sram_do_i (sramDo)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: byte writes and a registered read port.
    always @(posedge clk) begin
        if (sramCs) begin
            if (sramOe) sramDo <= mem[sramA[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (!sramWeb[b]) mem[sramA[7:0]][8*b +: 8] <= sramDi[8*b +: 8];
            end
        end
    end

    // Requester-side protocol watch: inputs stable while a request is
    // pending, and never two acks at once.
    logic              ifPend = 1'b0;
    logic              dmPend = 1'b0;
    logic [ADDR_W-1:0] ifAddrPrev = '0;
    logic [ADDR_W-1:0] dmAddrPrev = '0;
    logic [3:0]        dmWebPrev = 4'hF;
    logic [DATA_W-1:0] dmWdataPrev = '0;
    always @(posedge clk) begin
        if (rst) begin
            if (ifAck && dmAck) begin
                $display("[TB] FAIL protocol_dual_ack: both acks high");
                failures++;
            end
            if (ifPend && ifReq && ifAddr !== ifAddrPrev) begin
                $display("[TB] FAIL protocol_if_stable: addr %h was %h", ifAddr, ifAddrPrev);
                failures++;
            end
            if (dmPend && dmReq && {dmWeb, dmAddr, dmWdata} !== {dmWebPrev, dmAddrPrev, dmWdataPrev}) begin
                $display("[TB] FAIL protocol_dm_stable: dm inputs changed while pending");
                failures++;
            end
        end
        ifPend      <= rst && ifReq && !ifAck;
        dmPend      <= rst && dmReq && !dmAck;
        ifAddrPrev  <= ifAddr;
        dmAddrPrev  <= dmAddr;
        dmWebPrev   <= dmWeb;
        dmWdataPrev <= dmWdata;
    end

    // Reset held 3 cycles with both requests high, then DM issues on release.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        ifReq = 1'b1; ifAddr = 14'h05;
        dmReq = 1'b1; dmAddr = 14'h06; dmWeb = 4'hF; dmWdata = '0;
        mem[8'h06] = 32'h06060606;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if ({sramCs, sramWeb, ifAck, dmAck} !== {1'b0, 4'hF, 1'b0, 1'b0}) begin
                $display("[TB] FAIL reset_idle c=%0d: cs=%b web=%h ifAck=%b dmAck=%b, want cs=0 web=f acks=0",
                         c, sramCs, sramWeb, ifAck, dmAck);
                failures++;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({sramCs, sramA} !== {1'b1, 14'h06}) begin
            $display("[TB] FAIL reset_first_issue: cs=%b a=%h, want cs=1 a=0006", sramCs, sramA);
            failures++;
        end
        @(negedge clk);
        dmReq = 1'b0; ifReq = 1'b0;
        #1;
        checks++;
        if ({dmAck, dmRdata} !== {1'b1, 32'h06060606}) begin
            $display("[TB] FAIL reset_first_ack: dmAck=%b rdata=%h, want 1 06060606", dmAck, dmRdata);
            failures++;
        end
    endtask

    task automatic test_if_read();
        mem[8'h12] = 32'hDEADBEEF;
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 14'h12;
        #1;
        checks++;
        if ({sramCs, sramOe, sramWeb, sramA, ifAck, ifRdata} !== {1'b1, 1'b1, 4'hF, 14'h12, 1'b0, 32'h0}) begin
            $display("[TB] FAIL if_issue: cs=%b oe=%b web=%h a=%h ack=%b rdata=%h, want 1 1 f 0012 0 0",
                     sramCs, sramOe, sramWeb, sramA, ifAck, ifRdata);
            failures++;
        end
        @(negedge clk);
        ifReq = 1'b0;
        #1;
        checks++;
        if ({ifAck, ifRdata, sramCs, dmAck} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            $display("[TB] FAIL if_ack: ack=%b rdata=%h cs=%b dmAck=%b, want 1 deadbeef 0 0",
                     ifAck, ifRdata, sramCs, dmAck);
            failures++;
        end
    endtask

    task automatic test_dm_write_read();
        mem[8'h40] = 32'h11223344;
        @(negedge clk);
        dmReq = 1'b1; dmWeb = 4'b1101; dmAddr = 14'h40; dmWdata = 32'h0000AB00;
        #1;
        checks++;
        if ({sramCs, sramOe, sramWeb, sramA, sramDi} !== {1'b1, 1'b0, 4'b1101, 14'h40, 32'h0000AB00}) begin
            $display("[TB] FAIL dm_write_issue: cs=%b oe=%b web=%h a=%h di=%h, want 1 0 d 0040 0000ab00",
                     sramCs, sramOe, sramWeb, sramA, sramDi);
            failures++;
        end
        @(negedge clk);
        dmReq = 1'b0;
        #1;
        checks++;
        if ({dmAck, dmRdata, ifAck} !== {1'b1, 32'h0, 1'b0}) begin
            $display("[TB] FAIL dm_write_ack: ack=%b rdata=%h ifAck=%b, want 1 00000000 0", dmAck, dmRdata, ifAck);
            failures++;
        end
        @(negedge clk);
        dmReq = 1'b1; dmWeb = 4'hF; dmWdata = '0;
        #1;
        checks++;
        if ({sramCs, sramOe, sramWeb} !== {1'b1, 1'b1, 4'hF}) begin
            $display("[TB] FAIL dm_read_issue: cs=%b oe=%b web=%h, want 1 1 f", sramCs, sramOe, sramWeb);
            failures++;
        end
        @(negedge clk);
        dmReq = 1'b0;
        #1;
        checks++;
        if ({dmAck, dmRdata} !== {1'b1, 32'h1122AB44}) begin
            $display("[TB] FAIL dm_read_ack: ack=%b rdata=%h, want 1 1122ab44", dmAck, dmRdata);
            failures++;
        end
    endtask

    task automatic test_simultaneous();
        mem[8'h20] = 32'hCAFEF00D;
        mem[8'h30] = 32'h0BADC0DE;
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 14'h20;
        dmReq = 1'b1; dmAddr = 14'h30; dmWeb = 4'hF;
        #1;
        checks++;
        if ({sramCs, sramA} !== {1'b1, 14'h30}) begin
            $display("[TB] FAIL simul_dm_first: cs=%b a=%h, want 1 0030", sramCs, sramA);
            failures++;
        end
        @(negedge clk);
        dmReq = 1'b0;
        #1;
        checks++;
        if ({dmAck, dmRdata, ifAck, sramCs} !== {1'b1, 32'h0BADC0DE, 1'b0, 1'b0}) begin
            $display("[TB] FAIL simul_dm_ack: dmAck=%b rdata=%h ifAck=%b cs=%b, want 1 0badc0de 0 0",
                     dmAck, dmRdata, ifAck, sramCs);
            failures++;
        end
        @(negedge clk);
        #1;
        checks++;
        if ({sramCs, sramOe, sramA} !== {1'b1, 1'b1, 14'h20}) begin
            $display("[TB] FAIL simul_if_issue: cs=%b oe=%b a=%h, want 1 1 0020", sramCs, sramOe, sramA);
            failures++;
        end
        @(negedge clk);
        ifReq = 1'b0;
        #1;
        checks++;
        if ({ifAck, ifRdata, dmAck, dmRdata} !== {1'b1, 32'hCAFEF00D, 1'b0, 32'h0}) begin
            $display("[TB] FAIL simul_if_ack: ifAck=%b rdata=%h dmAck=%b dmRdata=%h, want 1 cafef00d 0 0",
                     ifAck, ifRdata, dmAck, dmRdata);
            failures++;
        end
    endtask

    // Continuous DM traffic with IF waiting: four DM acks, then IF, repeating.
    task automatic test_starvation();
        int firstIfAck;
        int dmBefore;
        logic expIf, expDm;
        firstIfAck = -1;
        dmBefore = 0;
        mem[8'h50] = 32'h50505050;
        mem[8'h51] = 32'h51515151;
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 14'h50;
        dmReq = 1'b1; dmAddr = 14'h51; dmWeb = 4'hF;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            expIf = (c == 9) || (c == 19);
            expDm = (c % 2 == 1) && !expIf;
            checks++;
            if ({ifAck, dmAck} !== {expIf, expDm}) begin
                $display("[TB] FAIL starve_acks c=%0d: ifAck=%b dmAck=%b, want %b %b", c, ifAck, dmAck, expIf, expDm);
                failures++;
            end
            if (expIf) begin
                checks++;
                if (ifRdata !== 32'h50505050) begin
                    $display("[TB] FAIL starve_if_data c=%0d: rdata=%h, want 50505050", c, ifRdata);
                    failures++;
                end
            end
            if (ifAck && firstIfAck < 0) firstIfAck = c;
            if (dmAck && firstIfAck < 0) dmBefore++;
        end
        checks++;
        if (firstIfAck != 9 || dmBefore != 4) begin
            $display("[TB] FAIL starve_latency: first IF ack cycle=%0d dm acks before=%0d, want 9 and 4",
                     firstIfAck, dmBefore);
            failures++;
        end
        @(negedge clk);
        ifReq = 1'b0; dmReq = 1'b0;
        @(negedge clk);
    endtask

    // Reset while IF_WAIT: the access is dropped and reissued on release.
    task automatic test_reset_mid_access();
        mem[8'h60] = 32'h600DF00D;
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 14'h60;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({ifAck, ifRdata, sramCs} !== {1'b0, 32'h0, 1'b0}) begin
            $display("[TB] FAIL midreset_no_ack: ack=%b rdata=%h cs=%b, want 0 0 0", ifAck, ifRdata, sramCs);
            failures++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({sramCs, sramA, ifAck} !== {1'b1, 14'h60, 1'b0}) begin
            $display("[TB] FAIL midreset_reissue: cs=%b a=%h ack=%b, want 1 0060 0", sramCs, sramA, ifAck);
            failures++;
        end
        @(negedge clk);
        ifReq = 1'b0;
        #1;
        checks++;
        if ({ifAck, ifRdata} !== {1'b1, 32'h600DF00D}) begin
            $display("[TB] FAIL midreset_ack: ack=%b rdata=%h, want 1 600df00d", ifAck, ifRdata);
            failures++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_if_read();
        test_dm_write_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_access();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one unified single-port SRAM between the CPU instruction-fetch (IF) requester and the data-memory (DM) requester.
- Used in the multi-cycle CPU variant, which has a single SRAM macro with registered output (read data valid one cycle after the access cycle) instead of separate zero-delay IM/DM macros.
- Provides a req/ack handshake per requester, fixed DM priority with an IF anti-starvation limit, and drives the SRAM control pins.

Parameters:
- ADDR_W, 14, SRAM word-address width (matches the 14-bit IM_A/DM_A word address).
- DATA_W, 32, data width.
- MAX_DM_STREAK, 4, max consecutive DM grants allowed while IF is pending; range 1..15.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- if_req_i  in  1  IF access request; held high with stable address until if_ack_o.
- if_addr_i  in  ADDR_W  IF word address.
- if_ack_o  out  1  one-cycle pulse: IF access complete, if_rdata_o valid.
- if_rdata_o  out  DATA_W  fetched word; valid only when if_ack_o=1, else 0.
- dm_req_i  in  1  DM access request; held high with stable inputs until dm_ack_o.
- dm_web_i  in  4  active-low byte write enables; 4'hF = read.
- dm_addr_i  in  ADDR_W  DM word address.
- dm_wdata_i  in  DATA_W  DM write data, already byte-aligned.
- dm_ack_o  out  1  one-cycle pulse: DM access complete.
- dm_rdata_o  out  DATA_W  read data; valid only on a read ack, else 0.
- sram_cs_o  out  1  SRAM chip select.
- sram_oe_o  out  1  SRAM output enable.
- sram_web_o  out  4  SRAM active-low byte write enables.
- sram_a_o  out  ADDR_W  SRAM address.
- sram_di_o  out  DATA_W  SRAM write data.
- sram_do_i  in  DATA_W  SRAM read data, valid the cycle after the access cycle.

Behaviour:
- FSM states: IDLE, IF_WAIT, DM_WAIT. Every access takes exactly 2 cycles (issue cycle in IDLE, ack cycle in *_WAIT). Peak throughput is 1 access per 2 cycles.
- IDLE, no request: sram_cs_o=0, sram_oe_o=0, sram_web_o=4'hF, sram_a_o=0, sram_di_o=0.
- IDLE, arbitration (combinational, same cycle):
  - Grant DM if dm_req_i=1, unless if_req_i=1 and streak==MAX_DM_STREAK; in that case grant IF.
  - Otherwise grant IF if if_req_i=1.
  - The granted requester's address and data drive the SRAM pins in the issue cycle. Next state is IF_WAIT or DM_WAIT.
- IF issue: cs=1, oe=1, web=4'hF, a=if_addr_i, di=0.
- DM issue: cs=1, a=dm_addr_i, web=dm_web_i, di=dm_wdata_i. oe=1 only if dm_web_i==4'hF, else oe=0.
- IF_WAIT: SRAM pins idle, if_ack_o=1, if_rdata_o=sram_do_i. Next state IDLE.
- DM_WAIT: SRAM pins idle, dm_ack_o=1. dm_rdata_o=sram_do_i for a read, 0 for a write (access type registered at issue). Next state IDLE.
- Requester contract: a req still high in the cycle after ack is treated as a new request with new address and data. No arbitration happens in *_WAIT, so there is no double issue.
- Streak counter (4 bits):
  - DM grant with if_req_i=1: increment, saturating at MAX_DM_STREAK.
  - DM grant with if_req_i=0: cleared.
  - IF grant: cleared.
- Worst-case IF latency with continuous DM traffic: 2*MAX_DM_STREAK+2 cycles from req to ack.
- Acks are mutually exclusive; at most one access is in flight.
- Reset (rst_i=0 at a clock edge):
  - state=IDLE, streak=0, acks=0, rdata outputs=0, SRAM pins idle.
  - Reset in a *_WAIT state abandons the access; no ack is ever produced for it.
  - In the reset cycle, the SRAM pins are forced idle even if requests are high.
- Inputs changing while a req is pending and unacked are a protocol violation; behaviour is undefined, and the bench asserts against it.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with both reqs high -> cs=0, web=4'hF, both acks 0 throughout; first issue occurs on the cycle rst_i=1 is sampled.
- Single IF read: preload word 0x12 = 32'hDEADBEEF; if_req_i=1, if_addr_i=0x12 -> cycle 0: cs=1, oe=1, a=0x12; cycle 1: if_ack_o=1, if_rdata_o=32'hDEADBEEF.
- DM byte write then read: dm_web_i=4'b1101, addr 0x40, wdata 32'h0000AB00, over old 32'h11223344 -> dm_ack_o next cycle with dm_rdata_o=0, oe=0 at issue; the following read returns 32'h1122AB44.
- Simultaneous requests: both high in IDLE -> DM granted first; dm_ack_o at cycle 1, IF issue at cycle 2, if_ack_o at cycle 3.
- Starvation limit (MAX_DM_STREAK=4): DM req continuous, IF req high -> exactly 4 DM acks, then 1 IF ack (IF req-to-ack = 10 cycles), then the DM pattern repeats.
- Reset mid-access: drop rst_i in IF_WAIT -> no if_ack_o; after release, the still-asserted if_req_i is reissued and acked 2 cycles later with correct data.
